// File: rtl/repeated_sub_divider_pkg.sv
// Shared definitions for the repeated-subtraction divider: default width and controller states.
package repeated_sub_divider_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CALC   = 3'd3,
    FIN    = 3'd4
  } div_state_t;

endpackage

// File: rtl/repeated_sub_divider_div_sub_cmp.sv
// Combinational compare/subtract step: GE = rem >= divisor, DIFF = rem - divisor when GE holds.
module div_sub_cmp #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_val,
  input  logic [WIDTH-1:0] divisor,
  output logic             ge,
  output logic [WIDTH-1:0] diff
);

  always_comb begin
    ge   = (rem_val >= divisor);
    diff = ge ? (rem_val - divisor) : '0;
  end

endmodule

// File: rtl/repeated_sub_divider.sv
// Sequential unsigned divider: loads dividend then divisor over DATA_IN, then subtracts once per cycle.
module repeated_sub_divider
  import repeated_sub_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] DATA_IN,
  output logic [WIDTH-1:0] QUOT,
  output logic [WIDTH-1:0] REM,
  output logic             BUSY,
  output logic             DONE,
  output logic             DIVZ
);

  div_state_t       state, next_state;
  logic [WIDTH-1:0] quot_q, rem_q, divisor_q;
  logic             divz_q;
  logic             start_op, ld_a, ld_b, sub_en;
  logic             ge;
  logic [WIDTH-1:0] diff;

  div_sub_cmp #(.WIDTH(WIDTH)) u_sub_cmp (
    .rem_val (rem_q),
    .divisor (divisor_q),
    .ge      (ge),
    .diff    (diff)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    start_op   = 1'b0;
    ld_a       = 1'b0;
    ld_b       = 1'b0;
    sub_en     = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          start_op   = 1'b1;
          next_state = LOAD_A;
        end
      end
      LOAD_A: begin
        ld_a       = 1'b1;
        next_state = LOAD_B;
      end
      LOAD_B: begin
        ld_b       = 1'b1;
        next_state = (DATA_IN == '0) ? FIN : CALC;
      end
      CALC: begin
        if (ge) sub_en = 1'b1;
        else    next_state = FIN;
      end
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Divide-by-zero is decided from DATA_IN directly so FIN follows LOAD_B without a CALC pass.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      quot_q    <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      divz_q    <= 1'b0;
    end else begin
      if (start_op) begin
        quot_q <= '0;
        divz_q <= 1'b0;
      end
      if (ld_a) rem_q <= DATA_IN;
      if (ld_b) begin
        divisor_q <= DATA_IN;
        if (DATA_IN == '0) begin
          divz_q <= 1'b1;
          quot_q <= '1;
        end
      end
      if (sub_en) begin
        rem_q  <= diff;
        quot_q <= quot_q + WIDTH'(1);
      end
    end
  end

  always_comb begin
    QUOT = quot_q;
    REM  = rem_q;
    DIVZ = divz_q;
    DONE = (state == FIN);
    BUSY = (state != IDLE);
  end

endmodule

// File: tb/tb_repeated_sub_divider.sv
// Self-checking bench for repeated_sub_divider: latency/arithmetic model plus directed vectors.
module tb_repeated_sub_divider;

  localparam int unsigned W = 16;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b1;
  logic         START = 1'b0;
  logic [W-1:0] DATA_IN = '0;
  logic [W-1:0] QUOT, REM;
  logic         BUSY, DONE, DIVZ;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  repeated_sub_divider #(.WIDTH(W)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .START   (START),
    .DATA_IN (DATA_IN),
    .QUOT    (QUOT),
    .REM     (REM),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .DIVZ    (DIVZ)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: edge count since START, result from plain division, DONE edge = 4+q (or 3 for /0).
  int           m_edge = 0;
  int           m_done_at = 0;
  logic [W-1:0] m_n, m_d, m_q, m_r;
  logic         m_z;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_edge = 0; m_q = '0; m_r = '0; m_z = 1'b0; m_done_at = 0;
    end else if (m_edge == 0) begin
      if (START) begin
        m_edge = 1; m_q = '0; m_z = 1'b0; m_done_at = 32'h7fffffff;
      end
    end else if (m_edge == m_done_at) begin
      m_edge = 0;
    end else begin
      if (m_edge == 1) m_n = DATA_IN;
      if (m_edge == 2) begin
        m_d = DATA_IN;
        if (m_d == 0) begin
          m_z = 1'b1; m_q = '1; m_r = m_n; m_done_at = 3;
        end else begin
          m_q = m_n / m_d; m_r = m_n % m_d; m_done_at = 4 + int'(m_q);
        end
      end
      m_edge++;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      if (m_edge == 0) begin
        check("idle_busy", BUSY, 0);
        check("idle_done", DONE, 0);
        check("idle_quot", QUOT, m_q);
        check("idle_rem",  REM,  m_r);
        check("idle_divz", DIVZ, m_z);
      end else begin
        check("run_busy", BUSY, 1);
        check("run_done", DONE, (m_edge == m_done_at));
        check("run_divz", DIVZ, (m_edge == m_done_at) && m_z);
        if (m_edge == m_done_at) begin
          check("done_quot", QUOT, m_q);
          check("done_rem",  REM,  m_r);
        end
      end
    end
  end

  task automatic load(input logic [W-1:0] n, input logic [W-1:0] d);
    @(posedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0; DATA_IN = n;
    @(posedge CLK); #1 DATA_IN = d;
    @(posedge CLK); #1 DATA_IN = W'($urandom);
  endtask

  task automatic do_div(input logic [W-1:0] n, input logic [W-1:0] d, input bit pulse,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input bit ez,
                        input int edone);
    int e;
    bit got;
    load(n, d);
    e = 3;
    got = 0;
    while (!got && e < 70000) begin
      @(negedge CLK);
      if (DONE) got = 1;
      else begin
        if (pulse) START = ~START;
        @(posedge CLK); e++;
        #1 DATA_IN = W'($urandom);
      end
    end
    check("timeout", got, 1);
    check("lit_edges", e, edone);
    check("lit_quot", QUOT, eq);
    check("lit_rem", REM, er);
    check("lit_divz", DIVZ, ez);
    if (pulse) START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    @(negedge CLK);
    check("lit_done_pulse", DONE, 0);
    check("lit_idle_after", BUSY, 0);
  endtask

  initial begin
    #2 RST_N = 1'b0;
    #1;
    check("rst_quot", QUOT, 0);
    check("rst_rem",  REM,  0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_divz", DIVZ, 0);
    @(posedge CLK); #1 RST_N = 1'b1;
    chk_en = 1'b1;

    do_div(16'd100,   16'd7,    0, 16'd14,    16'd2,  0, 18);
    do_div(16'd5,     16'd9,    0, 16'd0,     16'd5,  0, 4);
    do_div(16'hFFFF,  16'hFFFF, 0, 16'd1,     16'd0,  0, 5);
    do_div(16'h0400,  16'd1,    0, 16'h0400,  16'd0,  0, 1028);
    do_div(16'd42,    16'd0,    0, 16'hFFFF,  16'd42, 1, 3);
    do_div(16'd0,     16'd5,    0, 16'd0,     16'd0,  0, 4);

    load(16'd1000, 16'd3);
    repeat (10) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check("mid_rst_quot", QUOT, 0);
    check("mid_rst_rem",  REM,  0);
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_done", DONE, 0);
    check("mid_rst_divz", DIVZ, 0);
    @(posedge CLK); #1 RST_N = 1'b1;

    do_div(16'd20,    16'd4,    0, 16'd5,     16'd0,  0, 9);
    do_div(16'd50,    16'd5,    1, 16'd10,    16'd0,  0, 14);

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "global timeout");
  end

endmodule
